fifo_rd_stream: RTL and testbench

Read-side adapter for the team's synchronous 8-bit FIFO. It drives the FIFO's `rd_en`/`empty`/`dout` port and presents the words as a valid/ready stream to a downstream consumer. A 3-entry internal buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle with no combinational path from `m_ready` to `fifo_rd_en`. It sits between the FIFO and any stream consumer (UART TX, checker, scoreboard port).

---
 rtl/fifo_rd_stream.sv | 129 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side adapter for the synchronous FIFO. It issues rd_en against a
// 3-entry credit and parks returning words in a small circular buffer, then
// presents them as a valid/ready stream. The read strobe depends only on
// registered state plus fifo_empty and flush, never on m_ready.
module fifo_rd_stream #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam int DEPTH = 3;

   logic [DATA_W-1:0] r_buf [DEPTH];
   logic [1:0]        r_wp;
   logic [1:0]        r_rp;
   logic [1:0]        r_occ;
   logic              r_inflight;
   logic [CNT_W-1:0]  r_xfer_cnt;

   logic [2:0]        w_credit_used;
   logic              w_rd_en;
   logic              w_capture;
   logic              w_pop;
   logic              w_m_valid;
   logic [1:0]        w_wp_inc;
   logic [1:0]        w_rp_inc;
   logic [DEPTH-1:0]  w_buf_we;
   logic [DATA_W-1:0] w_m_data;

   // Words already buffered plus the one possibly returning from the FIFO.
   assign w_credit_used = {1'b0, r_occ} + {2'b00, r_inflight};

   // Read strobe is forced low during reset and flush.
   assign w_rd_en   = rst_n && !fifo_empty && !flush && (w_credit_used < 3'd3);
   assign w_capture = r_inflight && !flush;
   assign w_m_valid = (r_occ != 2'd0);
   assign w_pop     = w_m_valid && m_ready;

   // Pointers wrap from 2 back to 0.
   assign w_wp_inc = (r_wp == 2'd2) ? 2'd0 : r_wp + 2'd1;
   assign w_rp_inc = (r_rp == 2'd2) ? 2'd0 : r_rp + 2'd1;

   // Per-entry write enables decoded from the write pointer.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_we
         assign w_buf_we[gi] = w_capture && (r_wp == 2'(gi));
      end
   endgenerate

   // Buffer storage: cleared on reset, written by the capture strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_buf_we[i]) begin
               r_buf[i] <= fifo_dout;
            end
         end
      end
   end

   // Pointer, occupancy and in-flight tracking; flush empties everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp       <= 2'd0;
         r_rp       <= 2'd0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
      end else if (flush) begin
         r_wp       <= 2'd0;
         r_rp       <= 2'd0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_capture) begin
            r_wp <= w_wp_inc;
         end
         if (w_pop) begin
            r_rp <= w_rp_inc;
         end
         case ({w_capture, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Delivered-word counter; a pop during flush still counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xfer_cnt <= '0;
      end else if (w_pop) begin
         r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
   end

   // Output word selected by the read pointer (only values 0..2 occur).
   always_comb begin
      w_m_data = r_buf[0];
      case (r_rp)
         2'd1:    w_m_data = r_buf[1];
         2'd2:    w_m_data = r_buf[2];
         default: w_m_data = r_buf[0];
      endcase
   end

   assign fifo_rd_en = w_rd_en;
   assign m_valid    = w_m_valid;
   assign m_data     = w_m_data;
   assign xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO feeds the DUT and an
// expected-word queue checks every delivered word in order.
module tb_fifo_rd_stream;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_rd_en;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;
   logic [CNT_W-1:0]  xfer_cnt;

   int tests;
   int fails;
   int rd_pulses;
   int phase_pops;

   logic [7:0] mem [0:255];
   int         wr_idx;
   int         rd_idx;
   logic [7:0] exp_q [$];

   fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .xfer_cnt   (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous FIFO: dout registered one cycle after rd_en.
   assign fifo_empty = (wr_idx == rd_idx);
   initial fifo_dout = '0;
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_dout <= mem[rd_idx[7:0]];
         rd_idx    <= rd_idx + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_idx[7:0]] = d;
      wr_idx++;
      exp_q.push_back(d);
   endtask

   // Finish the current cycle: tally rd_en, check any pop, move to next negedge.
   task automatic step();
      logic [7:0] w;
      #1;
      if (fifo_rd_en) begin
         rd_pulses++;
         check("rd_while_empty", fifo_empty, 0);
      end
      if (m_valid && m_ready) begin
         phase_pops++;
         check("pop_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("order", m_data, w);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; rd_pulses = 0; phase_pops = 0;
      wr_idx = 0; rd_idx = 0;
      rst_n = 1'b1; flush = 1'b0; m_ready = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_xfer", xfer_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1; m_ready = 1'b1;
      step(); step();

      // T1: three words, m_ready high, latency and back-to-back delivery.
      push(8'h11); push(8'h22); push(8'h33);
      #1;
      check("t1_rd_en_N", fifo_rd_en, 1);
      check("t1_valid_N", m_valid, 0);
      step();
      #1;
      check("t1_valid_N1", m_valid, 0);
      step();
      #1;
      check("t1_valid_N2", m_valid, 1);
      check("t1_data_N2", m_data, 8'h11);
      step();
      #1;
      check("t1_data_N3", m_data, 8'h22);
      step();
      #1;
      check("t1_data_N4", m_data, 8'h33);
      step();
      #1;
      check("t1_valid_end", m_valid, 0);
      check("t1_xfer", xfer_cnt, 3);
      step();

      // T2: ten words under 8 cycles of backpressure, then full-rate drain.
      m_ready = 1'b0; rd_pulses = 0;
      for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 8; i++) begin
         #1;
         if (m_valid) check("t2_hold", m_data, 8'hA0);
         step();
      end
      #1;
      check("t2_rd_pulses", rd_pulses, 3);
      check("t2_valid", m_valid, 1);
      check("t2_data", m_data, 8'hA0);
      m_ready = 1'b1; phase_pops = 0;
      for (int i = 0; i < 10; i++) step();
      #1;
      check("t2_pops", phase_pops, 10);
      check("t2_valid_end", m_valid, 0);
      check("t2_xfer", xfer_cnt, 4'hD);
      step();

      // T3: twenty words with m_ready toggling 1,0,1,0.
      for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
      phase_pops = 0;
      for (int i = 0; i < 80 && phase_pops < 20; i++) begin
         m_ready = (i % 2 == 0);
         step();
      end
      m_ready = 1'b0;
      #1;
      check("t3_pops", phase_pops, 20);
      check("t3_xfer", xfer_cnt, 4'h1);
      check("t3_q_empty", exp_q.size(), 0);
      step(); step();

      // T4: two buffered plus one in flight, then a one-cycle flush.
      for (int i = 1; i <= 5; i++) push(8'h50 + 8'(i));
      step(); step(); step();
      flush = 1'b1;
      #1;
      check("t4_valid_pre", m_valid, 1);
      check("t4_data_pre", m_data, 8'h51);
      check("t4_rd_en_flush", fifo_rd_en, 0);
      void'(exp_q.pop_front()); void'(exp_q.pop_front()); void'(exp_q.pop_front());
      step();
      flush = 1'b0;
      #1;
      check("t4_valid_post", m_valid, 0);
      check("t4_rd_en_post", fifo_rd_en, 1);
      check("t4_xfer_hold", xfer_cnt, 4'h1);
      step();
      #1;
      check("t4_valid_post2", m_valid, 0);
      step();
      m_ready = 1'b1;
      #1;
      check("t4_valid_next", m_valid, 1);
      check("t4_data_next", m_data, 8'h54);
      step(); step(); step(); step();
      #1;
      check("t4_xfer_end", xfer_cnt, 4'h3);
      check("t4_valid_end", m_valid, 0);
      step();

      // T5: one-cycle reset in the middle of a stream.
      for (int i = 1; i <= 6; i++) push(8'h60 + 8'(i));
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      check("t5_valid_rst", m_valid, 0);
      check("t5_rd_en_rst", fifo_rd_en, 0);
      check("t5_xfer_rst", xfer_cnt, 0);
      check("t5_data_rst", m_data, 0);
      void'(exp_q.pop_front()); void'(exp_q.pop_front());
      step();
      rst_n = 1'b1; phase_pops = 0;
      for (int i = 0; i < 6; i++) step();
      #1;
      check("t5_pops", phase_pops, 3);
      check("t5_xfer", xfer_cnt, 4'h3);
      step();

      // T6: counter wrap in the 4-bit build: 11 more words to 14, then 3 to wrap.
      for (int i = 0; i < 11; i++) push(8'hC0 + 8'(i));
      for (int i = 0; i < 20; i++) step();
      #1;
      check("t6_xfer_14", xfer_cnt, 4'hE);
      step();
      push(8'hD1); push(8'hD2); push(8'hD3);
      for (int i = 0; i < 8; i++) step();
      #1;
      check("t6_xfer_wrap", xfer_cnt, 4'h1);
      check("t6_q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
